// File: rtl/spi_slave_axis.sv
// -----------------------------------------------------------------------------
// spi_slave_axis
//
// Purpose:
//   SPI mode-0 slave that receives DATA_WIDTH-bit frames, MSB first, and
//   presents each completed word on an AXI-Stream master interface.
//   sck, cs_n and mosi are asynchronous to clk. They are brought into the clk
//   domain through SYNC_STAGES-deep synchronizers and are edge-detected there.
//
// Optional feature (macro SPI_SLAVE_MISO_EN):
//   When defined, miso shifts out the last word accepted on m_axis, MSB first.
//   The shift starts from the value captured at frame start. After reset this
//   word is 0.
//   When undefined, miso is tied to 0 and no transmit register is built.
//
// Parameters:
//   DATA_WIDTH   bits per SPI frame (8..32)
//   SYNC_STAGES  synchronizer depth on sck/cs_n/mosi (2..3)
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   sck            SPI clock from master, idle low
//   cs_n           active-low chip select
//   mosi           serial data in, MSB first
//   miso           serial data out (see macro above)
//   m_axis_tdata   received word
//   m_axis_tvalid  received word valid
//   m_axis_tready  downstream ready
//   busy           high while a frame is in progress (SHIFT or WAIT_CS)
//   overrun        1-cycle pulse: a word completed while the held word was stalled
//   frame_err      1-cycle pulse: cs_n released part-way through a frame
// -----------------------------------------------------------------------------
module spi_slave_axis #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   sck_prev_reg;
  logic                   cs_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Preload to the idle bus state so that reset release creates no edges.
      sck_sync_reg  <= '0;
      cs_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sck_prev_reg  <= 1'b0;
      cs_prev_reg   <= 1'b1;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      sck_prev_reg  <= sck_sync_reg[SYNC_STAGES-1];
      cs_prev_reg   <= cs_sync_reg[SYNC_STAGES-1];
    end
  end

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic sck_rise;
  logic cs_fall;

  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_reg;
  assign cs_fall  = ~cs_s & cs_prev_reg;

  // ---------------------------------------------------------------------------
  // Post-reset settle window
  //
  // The synchronizers restart from cs_n=1. If the pin is already low, the
  // synchronized cs_n falls a few cycles after reset release, but the master
  // is mid-frame. While this window is open, a low cs_n sends the FSM
  // straight to WAIT_CS so that the truncated frame is ignored silently.
  // ---------------------------------------------------------------------------
  logic [2:0] settle_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_reg <= 3'(SYNC_STAGES + 1);
    end else if (settle_reg != 3'd0) begin
      settle_reg <= settle_reg - 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t                state_reg;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  done_reg;
  logic                  done_next;
  logic                  ferr_reg;
  logic                  ferr_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (settle_reg != 3'd0 && !cs_s) begin
          state_next = WAIT_CS;
        end else if (cs_fall) begin
          state_next = SHIFT;
          cnt_next   = '0;
          shift_next = '0;
        end
      end
      SHIFT: begin
        // Releasing chip select takes priority over a coincident sck edge.
        if (cs_s) begin
          state_next = IDLE;
          cnt_next   = '0;
          shift_next = '0;
          if (cnt_reg != '0) begin
            ferr_next = 1'b1;
          end
        end else if (sck_rise) begin
          shift_next = {shift_reg[DATA_WIDTH-2:0], mosi_s};
          cnt_next   = cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
            done_next  = 1'b1;
            state_next = WAIT_CS;
          end
        end
      end
      WAIT_CS: begin
        if (cs_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      done_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      done_reg  <= done_next;
      ferr_reg  <= ferr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // AXI-Stream output stage
  //
  // done_reg fires one cycle after the last bit is shifted in. shift_reg is
  // then frozen in WAIT_CS, so it is loaded directly. A completion that
  // coincides with a handshake replaces the outgoing word. A completion
  // against a stalled word is dropped and flagged.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] tdata_reg;
  logic                  tvalid_reg;
  logic                  overrun_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tdata_reg   <= '0;
      tvalid_reg  <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (done_reg) begin
        if (tvalid_reg && !m_axis_tready) begin
          overrun_reg <= 1'b1;
        end else begin
          tdata_reg  <= shift_reg;
          tvalid_reg <= 1'b1;
        end
      end else if (tvalid_reg && m_axis_tready) begin
        tvalid_reg <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign overrun       = overrun_reg;
  assign frame_err     = ferr_reg;
  assign busy          = (state_reg != IDLE);

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------
`ifdef SPI_SLAVE_MISO_EN
  logic [DATA_WIDTH-1:0] tx_reg;
  logic [DATA_WIDTH-1:0] acc_reg;
  logic                  sck_fall;
  logic                  tx_start;

  assign sck_fall = ~sck_s & sck_prev_reg;
  assign tx_start = (state_reg == IDLE) && (state_next == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_reg  <= '0;
      acc_reg <= '0;
    end else begin
      if (tvalid_reg && m_axis_tready) begin
        acc_reg <= tdata_reg;
      end
      // The load at frame start puts the MSB on miso well before the first
      // sck rise. Each later falling edge moves the next bit up.
      if (tx_start) begin
        tx_reg <= acc_reg;
      end else if (state_reg == SHIFT && sck_fall && !cs_s) begin
        tx_reg <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign miso = tx_reg[DATA_WIDTH-1];
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_axis.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_axis
//
// Purpose:
//   Directed-vector bench for spi_slave_axis with DATA_WIDTH=32 and
//   SYNC_STAGES=2.
//   The stimulus pushes each word expected on m_axis into a scoreboard queue.
//   An independent monitor pops and compares that queue on every handshake.
//   The monitor also counts overrun and frame_err pulses.
//   The expected miso pattern follows the SPI_SLAVE_MISO_EN macro.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_spi_slave_axis;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sck = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          busy;
  logic          overrun;
  logic          frame_err;

  spi_slave_axis #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sck          (sck),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .busy         (busy),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          beats = 0;
  int          ovr_cnt = 0;
  int          ferr_cnt = 0;
  int unsigned hs_last = 0;
  int unsigned hs_prev = 0;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge.
  // Inputs change only on falling edges, so tvalid and tready are stable here
  // up to the next rising edge, where any handshake takes place.
  initial begin : monitor
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (overrun)   ovr_cnt++;
      if (frame_err) ferr_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        hs_prev = hs_last;
        hs_last = cyc;
        $display("beat %0d tdata=%h cycle=%0d", beats, m_axis_tdata, cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got tdata=%h, required no beat", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("beat_tdata", m_axis_tdata, e);
        end
      end
    end
  end

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_in_frame", 32'(busy), 32'd1);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // Sends n bits of w, MSB first, at sck = clk/8.
  // The miso value is captured just before each sck rise.
  // lat: checks tvalid around the final rising edge.
  // rdy: raises tready in the cycle where the final word is loaded.
  task automatic send_bits(input logic [31:0] w, input int n, input bit lat,
                           input bit rdy, output logic [31:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      sck  = 1'b0;
      mosi = w[31-i];
      repeat (4) @(negedge clk);
      mi  = {mi[30:0], miso};
      sck = 1'b1;
      for (int j = 1; j <= 4; j++) begin
        @(negedge clk);
        if (i == n - 1) begin
          if (rdy && j == 3) m_axis_tready = 1'b1;
          if (lat && j == 3) check("tvalid_before_latency", 32'(m_axis_tvalid), 32'd0);
          if (lat && j == 4) check("tvalid_at_3_cycles", 32'(m_axis_tvalid), 32'd1);
        end
      end
    end
    sck = 1'b0;
    @(negedge clk);
    if (lat) check("tvalid_one_cycle", 32'(m_axis_tvalid), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] w, input bit lat, input bit rdy,
                       output logic [31:0] mi);
    cs_low();
    send_bits(w, 32, lat, rdy, mi);
    cs_high();
    $display("frame sent %h", w);
  endtask

  initial begin : stim
    logic [31:0] mi;
    logic [31:0] exp_mi;
    int o0;
    int f0;
    int b0;

    // Reset state
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_tvalid",    32'(m_axis_tvalid), 32'd0);
    check("rst_tdata",     m_axis_tdata,       32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_miso",      32'(miso),          32'd0);
    check("rst_overrun",   32'(overrun),       32'd0);
    check("rst_frame_err", 32'(frame_err),     32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Single frame: 3-cycle latency, tvalid high for one cycle
    b0 = beats;
    exp_q.push_back(32'hA5C3_0F81);
    frame(32'hA5C3_0F81, 1'b1, 1'b0, mi);
    check("beats_single", 32'(beats - b0), 32'd1);

    // Stalled output: the second word is dropped with an overrun pulse
    m_axis_tready = 1'b0;
    o0 = ovr_cnt;
    b0 = beats;
    exp_q.push_back(32'h1111_1111);
    frame(32'h1111_1111, 1'b0, 1'b0, mi);
    frame(32'h2222_2222, 1'b0, 1'b0, mi);
    check("overrun_once",  32'(ovr_cnt - o0),   32'd1);
    check("held_tdata",    m_axis_tdata,        32'h1111_1111);
    check("held_tvalid",   32'(m_axis_tvalid),  32'd1);
    m_axis_tready = 1'b1;
    repeat (4) @(negedge clk);
    check("beats_stalled", 32'(beats - b0),     32'd1);
    check("tvalid_drained", 32'(m_axis_tvalid), 32'd0);

    // Truncated frame (13 bits) followed by a good frame
    f0 = ferr_cnt;
    b0 = beats;
    cs_low();
    send_bits(32'hFFFF_FFFF, 13, 1'b0, 1'b0, mi);
    cs_high();
    check("frame_err_once", 32'(ferr_cnt - f0), 32'd1);
    check("no_beat_trunc",  32'(beats - b0),    32'd0);
    exp_q.push_back(32'h0000_00FF);
    frame(32'h0000_00FF, 1'b0, 1'b0, mi);
    check("beats_after_err", 32'(beats - b0),   32'd1);

    // Reset mid-frame with cs_n held low: the frame is ignored silently
    f0 = ferr_cnt;
    b0 = beats;
    cs_low();
    send_bits(32'h5555_5555, 10, 1'b0, 1'b0, mi);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_wait_cs_after_rst", 32'(busy), 32'd1);
    send_bits(32'hFFFF_FFFF, 22, 1'b0, 1'b0, mi);
    cs_high();
    check("no_ferr_after_rst", 32'(ferr_cnt - f0), 32'd0);
    check("no_beat_after_rst", 32'(beats - b0),    32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    frame(32'hDEAD_BEEF, 1'b0, 1'b0, mi);
    check("beats_after_rst", 32'(beats - b0),      32'd1);

    // Second word completes in the handshake cycle of the first
    m_axis_tready = 1'b0;
    o0 = ovr_cnt;
    b0 = beats;
    exp_q.push_back(32'h0BAD_F00D);
    frame(32'h0BAD_F00D, 1'b0, 1'b0, mi);
    exp_q.push_back(32'h600D_CAFE);
    frame(32'h600D_CAFE, 1'b0, 1'b1, mi);
    check("b2b_no_overrun", 32'(ovr_cnt - o0),   32'd0);
    check("b2b_beats",      32'(beats - b0),     32'd2);
    check("b2b_adjacent",   32'(hs_last - hs_prev), 32'd1);

    // miso returns the last accepted word during the following frame
    exp_q.push_back(32'h1234_5678);
    frame(32'h1234_5678, 1'b0, 1'b0, mi);
    exp_q.push_back(32'h9ABC_DEF0);
    frame(32'h9ABC_DEF0, 1'b0, 1'b0, mi);
`ifdef SPI_SLAVE_MISO_EN
    exp_mi = 32'h1234_5678;
`else
    exp_mi = 32'h0000_0000;
`endif
    check("miso_word", mi, exp_mi);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_axis.md
SPI_SLAVE_AXIS -- requirements
Module: spi_slave_axis

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, bits per SPI frame (legal 8..32).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, synchronizer depth on sck, cs_n and mosi (legal 2..3).
REQ-003 SHALL provide port clk, input, 1, single system clock; all logic rising-edge.
REQ-004 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL provide port sck, input, 1, SPI clock from master, asynchronous to clk, idle low.
REQ-006 SHALL provide port cs_n, input, 1, active-low chip select, asynchronous.
REQ-007 SHALL provide port mosi, input, 1, serial data in, MSB first.
REQ-008 SHALL provide port miso, output, 1, serial data out (see Configuration).
REQ-009 SHALL provide ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1) and m_axis_tready (input, 1), the AXI-Stream received-word output.
REQ-010 SHALL provide port busy, output, 1, high while a frame is in progress.
REQ-011 SHALL provide ports overrun and frame_err, output, 1 each, single-cycle error pulses.

Function
REQ-012 SHALL use SPI mode 0: mosi sampled on synchronized sck rising edge; miso updated on sck falling edge.
REQ-013 SHALL support sck frequency up to clk/8, with a minimum cs_n high time of 4 clk cycles.
REQ-014 SHALL implement FSM IDLE, SHIFT, WAIT_CS, reset state IDLE.
REQ-015 IDLE->SHIFT on synchronized cs_n falling edge; bit counter cleared, shift register cleared.
REQ-016 In SHIFT, each sck rising edge SHALL shift mosi into the LSB and increment the counter.
REQ-017 On the DATA_WIDTH-th bit, SHALL present the word to the output stage and go to WAIT_CS.
REQ-018 In WAIT_CS, further sck edges SHALL be ignored; cs_n high -> IDLE.
REQ-019 cs_n rising in SHIFT with 0 < count < DATA_WIDTH SHALL pulse frame_err for 1 cycle, discard the partial word and go to IDLE; count 0 gives no error.
REQ-020 m_axis_tvalid SHALL assert exactly 3 clk cycles after the clk edge at which pin sck first samples high for the final bit (SYNC_STAGES=2), and 1 cycle later per extra stage.
REQ-021 tdata/tvalid SHALL be held stable until the cycle in which tvalid and tready are both high; tvalid deasserts the following cycle unless a new word loads.
REQ-022 A word completing while tvalid=1 and tready=0 SHALL be dropped, the held word kept, and overrun pulsed for 1 cycle.
REQ-023 A word completing in the same cycle as a tvalid&tready handshake SHALL load, with tvalid remaining high and no overrun.
REQ-024 busy SHALL be high in SHIFT and WAIT_CS, low in IDLE.

Reset
REQ-025 On rst: FSM IDLE, counter 0, shift register 0, m_axis_tdata 0, m_axis_tvalid 0, overrun 0, frame_err 0, busy 0, miso 0, synchronizers preloaded to idle (sck 0, cs_n 1).
REQ-026 If cs_n is low when rst releases, SHALL enter WAIT_CS and ignore that frame without frame_err.
REQ-027 rst asserted mid-frame SHALL discard the partial word and any pending output word.

Configuration
REQ-028 With macro SPI_SLAVE_MISO_EN defined, miso SHALL shift out, MSB first, the last word accepted on m_axis (0 after reset), loaded at frame start, first bit valid before the first sck rising edge.
REQ-029 Without SPI_SLAVE_MISO_EN, miso SHALL be constant 0 and no transmit register exists.

Verification
REQ-030 Frame 0xA5C3_0F81 at sck=clk/8, tready=1 -> one beat tdata=0xA5C3_0F81, tvalid high 1 cycle, at 3-cycle latency.
REQ-031 Two frames 0x1111_1111, 0x2222_2222 with tready=0 -> tdata holds 0x1111_1111, overrun pulses once; tready=1 -> only 0x1111_1111 delivered.
REQ-032 cs_n rises after 13 bits -> frame_err pulses once, no tvalid; next full frame 0x0000_00FF -> received correctly.
REQ-033 rst pulsed after 10 bits with cs_n held low -> no output, no frame_err for that frame; next cs_n cycle frame 0xDEAD_BEEF -> received.
REQ-034 Second frame completes in handshake cycle of first -> back-to-back beats, no overrun.
REQ-035 SPI_SLAVE_MISO_EN defined: frame 0x1234_5678 then second frame -> miso bits of second frame = 0x1234_5678; undefined -> miso stays 0.
